fp32_split_wallace_mult: RTL and testbench

- Front end of the binary32 floating-point multiplier datapath.
- Splits two IEEE-754 single-precision operands into sign, exponent and fraction fields.
- Forms 32-bit zero-extended significands with the implicit bit restored only for nonzero exponents.
- Multiplies the significands with a Wallace-tree multiplier to a full 64-bit unsigned product.
- Downstream logic (exponent add, normalisation, special-case handling) consumes these outputs; this block does none of that.

---
 rtl/fp32_split_wallace_mult.sv | 153 +++++++++++++++
 tb/tb_fp32_split_wallace_mult.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fp32_split_wallace_mult.sv
// Binary32 multiplier front end: splits both operands into fields and forms the
// exact 64-bit significand product through a carry-save (Wallace) tree and a final adder.
module fp32_split_wallace_mult (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic        s_a,
   output logic [7:0]  e_a,
   output logic [22:0] m_a,
   output logic        s_b,
   output logic [7:0]  e_b,
   output logic [22:0] m_b,
   output logic        sign_p,
   output logic [63:0] prod
);

   // Stage 1: field split and significand formation
   logic [31:0] na_d, nb_d;
   logic        sign_d;

   logic        v1_q;
   logic        sa1_q, sb1_q, sign1_q;
   logic [7:0]  ea1_q, eb1_q;
   logic [22:0] ma1_q, mb1_q;
   logic [31:0] na_q, nb_q;

   // Stage 2: product and delayed fields
   logic [63:0] prod_d;

   logic        v2_q;
   logic        sa2_q, sb2_q, sign2_q;
   logic [7:0]  ea2_q, eb2_q;
   logic [22:0] ma2_q, mb2_q;
   logic [63:0] prod_q;

   // Hidden bit is set for any nonzero exponent, including the all-ones exponent.
   always_comb begin
      na_d   = {8'b0, |a[30:23], a[22:0]};
      nb_d   = {8'b0, |b[30:23], b[22:0]};
      sign_d = a[31] ^ b[31];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         sa1_q   <= 1'b0;
         sb1_q   <= 1'b0;
         sign1_q <= 1'b0;
         ea1_q   <= 8'd0;
         eb1_q   <= 8'd0;
         ma1_q   <= 23'd0;
         mb1_q   <= 23'd0;
         na_q    <= 32'd0;
         nb_q    <= 32'd0;
      end else begin
         v1_q    <= in_valid;
         sa1_q   <= a[31];
         sb1_q   <= b[31];
         sign1_q <= sign_d;
         ea1_q   <= a[30:23];
         eb1_q   <= b[30:23];
         ma1_q   <= a[22:0];
         mb1_q   <= b[22:0];
         na_q    <= na_d;
         nb_q    <= nb_d;
      end
   end

   // Reduction layers: level 0 holds the 32 partial-product rows; each later level
   // compresses triples with full adders and a leftover pair with half adders.
   // Row counts go 32,22,15,10,7,5,4,3,2 so eight layers leave exactly two rows.
   logic [63:0] pp [0:8][0:31];
   logic [63:0] x, y, z;
   int          cnt, grp, rem;

   always_comb begin
      x   = '0;
      y   = '0;
      z   = '0;
      cnt = 32;
      grp = 0;
      rem = 0;
      for (int l = 0; l < 9; l++) begin
         for (int r = 0; r < 32; r++) begin
            pp[l][r] = '0;
         end
      end
      for (int j = 0; j < 32; j++) begin
         pp[0][j] = {64{nb_q[j]}} & ({32'b0, na_q} << j);
      end
      for (int l = 0; l < 8; l++) begin
         grp = cnt / 3;
         rem = cnt % 3;
         for (int g = 0; g < 10; g++) begin
            if (g < grp) begin
               x = pp[l][3*g];
               y = pp[l][3*g+1];
               z = pp[l][3*g+2];
               pp[l+1][2*g]   = x ^ y ^ z;
               pp[l+1][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
            end
         end
         if (rem == 2) begin
            x = pp[l][3*grp];
            y = pp[l][3*grp+1];
            pp[l+1][2*grp]   = x ^ y;
            pp[l+1][2*grp+1] = (x & y) << 1;
         end else if (rem == 1) begin
            pp[l+1][2*grp] = pp[l][3*grp];
         end
         cnt = 2 * grp + rem;
      end
      prod_d = pp[8][0] + pp[8][1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2_q    <= 1'b0;
         sa2_q   <= 1'b0;
         sb2_q   <= 1'b0;
         sign2_q <= 1'b0;
         ea2_q   <= 8'd0;
         eb2_q   <= 8'd0;
         ma2_q   <= 23'd0;
         mb2_q   <= 23'd0;
         prod_q  <= 64'd0;
      end else begin
         v2_q    <= v1_q;
         sa2_q   <= sa1_q;
         sb2_q   <= sb1_q;
         sign2_q <= sign1_q;
         ea2_q   <= ea1_q;
         eb2_q   <= eb1_q;
         ma2_q   <= ma1_q;
         mb2_q   <= mb1_q;
         prod_q  <= prod_d;
      end
   end

   assign out_valid = v2_q;
   assign s_a       = sa2_q;
   assign e_a       = ea2_q;
   assign m_a       = ma2_q;
   assign s_b       = sb2_q;
   assign e_b       = eb2_q;
   assign m_b       = mb2_q;
   assign sign_p    = sign2_q;
   assign prod      = prod_q;

endmodule

// File: tb/tb_fp32_split_wallace_mult.sv
// Bench for fp32_split_wallace_mult: directed test-plan vectors with fixed products,
// a mid-flight reset, then a randomized sweep against an arithmetic reference model.
module tb_fp32_split_wallace_mult;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a, b;
   logic        out_valid, s_a, s_b, sign_p;
   logic [7:0]  e_a, e_b;
   logic [22:0] m_a, m_b;
   logic [63:0] prod;

   fp32_split_wallace_mult dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .s_a       (s_a),
      .e_a       (e_a),
      .m_a       (m_a),
      .s_b       (s_b),
      .e_b       (e_b),
      .m_b       (m_b),
      .sign_p    (sign_p),
      .prod      (prod)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic [31:0] a;
      logic [31:0] b;
   } stage_t;

   stage_t      st1, st2;
   logic [63:0] exp_q[$];
   int          n_checks;
   int          n_pass;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
   endtask

   function automatic logic [63:0] sig_of(input logic [31:0] x);
      return (x[30:23] != 8'd0) ? 64'(32'h0080_0000 + x[22:0]) : 64'(x[22:0]);
   endfunction

   // Compare every output against the pair that entered two edges ago (all zero after reset).
   task automatic check_outputs();
      longint unsigned want;
      want = sig_of(st2.a) * sig_of(st2.b);
      check("out_valid", 64'(out_valid), 64'(st2.v));
      check("s_a",    64'(s_a),    64'(st2.a[31]));
      check("e_a",    64'(e_a),    64'(st2.a[30:23]));
      check("m_a",    64'(m_a),    64'(st2.a[22:0]));
      check("s_b",    64'(s_b),    64'(st2.b[31]));
      check("e_b",    64'(e_b),    64'(st2.b[30:23]));
      check("m_b",    64'(m_b),    64'(st2.b[22:0]));
      check("sign_p", 64'(sign_p), 64'(st2.a[31] ^ st2.b[31]));
      check("prod",   prod,        want);
      if (st2.v && exp_q.size() > 0) check("tp_prod", prod, exp_q.pop_front());
   endtask

   // driver: apply one cycle of inputs, advance model, check outputs after the edge
   task automatic cycle(input logic rst, input logic v, input logic [31:0] ai, input logic [31:0] bi);
      rst_n    = ~rst;
      in_valid = v;
      a        = ai;
      b        = bi;
      @(posedge clk);
      if (rst) begin
         st1 = '0;
         st2 = '0;
      end else begin
         st2 = st1;
         st1 = '{v: v, a: ai, b: bi};
      end
      #1;
      check_outputs();
   endtask

   task automatic issue(input logic [31:0] ai, input logic [31:0] bi, input logic [63:0] p);
      exp_q.push_back(p);
      cycle(1'b0, 1'b1, ai, bi);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 7))
         0: r[30:23] = 8'h00;
         1: r[30:23] = 8'hFF;
         2: r[22:0]  = 23'h7FFFFF;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      n_checks = 0;
      n_pass   = 0;
      st1      = '0;
      st2      = '0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = 32'd0;
      b        = 32'd0;

      cycle(1'b1, 1'b1, 32'h4000_0000, 32'h4080_0000);
      cycle(1'b1, 1'b1, 32'h4000_0000, 32'h4080_0000);

      issue(32'h4000_0000, 32'h4080_0000, 64'h0000_4000_0000_0000);
      idle(2);
      issue(32'h42FA_4000, 32'h4141_0000, 64'h0000_BCAA_4000_0000);
      issue(32'h40C8_0000, 32'h40BE_6666, 64'h0000_94BF_FFB0_0000);
      idle(2);
      issue(32'h7F80_0000, 32'h7380_0000, 64'h0000_4000_0000_0000);
      issue(32'h40C8_0000, 32'h0000_0000, 64'h0000_0000_0000_0000);
      issue(32'h0000_0001, 32'h3F80_0000, 64'h0000_0000_0080_0000);
      issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h0000_FFFF_FE00_0001);
      issue(32'hC000_0000, 32'h4000_0000, 64'h0000_4000_0000_0000);
      idle(2);
      check("tp_drained", 64'(exp_q.size()), 64'd0);

      // two valid pairs in flight, then reset: neither may emerge
      cycle(1'b0, 1'b1, 32'h3FC0_0000, 32'h4040_0000);
      cycle(1'b0, 1'b1, 32'h4110_0000, 32'hC0A0_0000);
      cycle(1'b1, 1'b1, 32'h4120_0000, 32'h4120_0000);
      idle(3);

      for (int i = 0; i < 10000; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), rand_op(), rand_op());
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
